// File: rtl/mem_bus_responder.sv
// Word-addressed memory responder: IDLE/WAIT/RESP handshake with WAIT_CYCLES wait states.
// Define MEM_RESP_ERR_EN to flag out-of-range addresses on mem_err instead of wrapping.
module mem_bus_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_addr_in,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_ready,
  output logic                  busy
`ifdef MEM_RESP_ERR_EN
  ,
  output logic                  mem_err
`endif
);

  localparam int IDX = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    req;
  logic                    take;
  logic                    enter_resp;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   cur_data;
  logic                    cur_wr;
  logic                    oor;
  logic                    commit;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign req  = mem_read_en | mem_write_en;
  assign take = (state == IDLE) && req;

  // With no wait states the access resolves on the accepting edge itself
  assign enter_resp = (take && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0));

  assign cur_addr = take ? mem_addr_in  : addr_q;
  assign cur_data = take ? mem_data_in  : data_q;
  assign cur_wr   = take ? mem_write_en : wr_q;

`ifdef MEM_RESP_ERR_EN
  logic err_q;
  assign oor = |(cur_addr >> IDX);
`else
  logic unused_hi;
  assign oor       = 1'b0;
  assign unused_hi = ^(cur_addr >> IDX);
`endif

  assign commit  = reset && enter_resp && cur_wr && !oor;
  assign rd_word = mem[cur_addr[IDX-1:0]];

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[cur_addr[IDX-1:0]] <= cur_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      mem_ready    <= 1'b0;
      busy         <= 1'b0;
      mem_data_out <= '0;
`ifdef MEM_RESP_ERR_EN
      err_q        <= 1'b0;
      mem_err      <= 1'b0;
`endif
    end else begin
      mem_ready <= (state == RESP);
`ifdef MEM_RESP_ERR_EN
      mem_err   <= (state == RESP) && err_q;
`endif
      unique case (1'b1)
        (state == IDLE): begin
          if (req) begin
            addr_q <= mem_addr_in;
            data_q <= mem_data_in;
            wr_q   <= mem_write_en;
            busy   <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        (state == WAIT): begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        (state == RESP): begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (enter_resp) begin
`ifdef MEM_RESP_ERR_EN
        err_q <= oor;
`endif
        if (!cur_wr) begin
          mem_data_out <= oor ? '0 : rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: transaction-level model plus directed cases.
// Expectations for out-of-range addresses follow MEM_RESP_ERR_EN.
module tb_mem_bus_responder;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;
  localparam int WC    = 2;
`ifdef MEM_RESP_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_addr_in;
  logic [DW-1:0] mem_data_in;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [DW-1:0] mem_data_out;
  logic          mem_ready;
  logic          busy;
  logic          mem_err;

  logic [AW-1:0] z_addr;
  logic [DW-1:0] z_din;
  logic          z_rd;
  logic          z_wr;
  logic [DW-1:0] z_dout;
  logic          z_ready;
  logic          z_busy;
  logic          z_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .DEPTH(DEPTH), .WAIT_CYCLES(WC)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .mem_addr_in(mem_addr_in),
    .mem_data_in(mem_data_in),
    .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out),
    .mem_ready(mem_ready),
    .busy(busy)
`ifdef MEM_RESP_ERR_EN
    ,
    .mem_err(mem_err)
`endif
  );

  mem_bus_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .DEPTH(DEPTH), .WAIT_CYCLES(0)
  ) u_w0 (
    .clk(clk),
    .reset(reset),
    .mem_addr_in(z_addr),
    .mem_data_in(z_din),
    .mem_read_en(z_rd),
    .mem_write_en(z_wr),
    .mem_data_out(z_dout),
    .mem_ready(z_ready),
    .busy(z_busy)
`ifdef MEM_RESP_ERR_EN
    ,
    .mem_err(z_err)
`endif
  );

`ifndef MEM_RESP_ERR_EN
  assign mem_err = 1'b0;
  assign z_err   = 1'b0;
`endif

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: accepted at edge N, effects at N+WC, pulse at N+1+WC
  int            cyc = 0;
  bit            checking = 0;
  bit            acc_v;
  int            acc_n;
  logic [AW-1:0] acc_a;
  logic [DW-1:0] acc_d;
  bit            acc_w;
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] m_dout;
  bit            m_ready, m_busy, m_err;

  always @(posedge clk) begin
    bit oor;
    int idx;
    cyc++;
    if (!reset) begin
      checking = 1;
      acc_v = 0; m_dout = '0;
      m_ready = 0; m_busy = 0; m_err = 0;
    end else begin
      m_ready = 0;
      m_err = 0;
      if (acc_v) begin
        if (cyc == acc_n + 1 + WC) begin
          m_ready = 1;
          m_err = ERR_BUILD && (int'(acc_a) >= DEPTH);
          acc_v = 0;
        end
      end else if (mem_read_en || mem_write_en) begin
        acc_v = 1; acc_n = cyc;
        acc_a = mem_addr_in; acc_d = mem_data_in;
        acc_w = mem_write_en;
      end
      if (acc_v && cyc == acc_n + WC) begin
        oor = ERR_BUILD && (int'(acc_a) >= DEPTH);
        idx = int'(acc_a) % DEPTH;
        if (acc_w) begin
          if (!oor) ref_mem[idx] = acc_d;
        end else begin
          m_dout = oor ? '0 : ref_mem[idx];
        end
      end
      m_busy = acc_v && (cyc <= acc_n + WC);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("ready", {31'b0, mem_ready}, {31'b0, m_ready});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("data_out", mem_data_out, m_dout);
      chk("err", {31'b0, mem_err}, {31'b0, m_err});
    end
  end

  task automatic do_txn(input bit rd, input bit wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit b2b, output int acc, output int rdy);
    if (!b2b) @(negedge clk);
    mem_addr_in = a; mem_data_in = d;
    mem_read_en = rd; mem_write_en = wr;
    acc = cyc + 1;
    rdy = -1;
    for (int i = 0; i < 40 && rdy < 0; i++) begin
      @(negedge clk);
      if (mem_ready) rdy = cyc;
    end
    mem_read_en = 0; mem_write_en = 0;
    if (rdy < 0) chk("txn_timeout", 0, 1);
  endtask

  initial begin
    int a, r, n, pulses, adj;
    bit prev;
    reset = 0;
    mem_addr_in = '0; mem_data_in = '0;
    mem_read_en = 0; mem_write_en = 0;
    z_addr = '0; z_din = '0; z_rd = 0; z_wr = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("rst_ready", {31'b0, mem_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_dout", mem_data_out, 0);

    do_txn(0, 1, 16'h0010, 32'hDEADBEEF, 0, a, r);
    chk("wr_latency", r - a, 3);
    chk("wr_keeps_dout", mem_data_out, 0);
    do_txn(1, 0, 16'h0010, '0, 0, a, r);
    chk("rd_latency", r - a, 3);
    chk("rd_data", mem_data_out, 32'hDEADBEEF);

    do_txn(1, 1, 16'h0020, 32'h12345678, 0, a, r);
    do_txn(1, 0, 16'h0020, '0, 0, a, r);
    chk("wr_priority", mem_data_out, 32'h12345678);

    do_txn(0, 1, 16'h0040, 32'hA5A5_0F0F, 0, a, r);
    do_txn(1, 0, 16'h0040, '0, 1, a, r);
    chk("b2b_raw", mem_data_out, 32'hA5A5_0F0F);

    do_txn(0, 1, 16'h0030, 32'h0BADF00D, 0, a, r);
    @(negedge clk);
    mem_addr_in = 16'h0030; mem_data_in = 32'h1111_1111;
    mem_write_en = 1;
    @(negedge clk);
    reset = 0; mem_write_en = 0;
    @(negedge clk);
    reset = 1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready) n++;
    end
    chk("abort_no_ready", n, 0);
    do_txn(1, 0, 16'h0030, '0, 0, a, r);
    chk("abort_keep", mem_data_out, 32'h0BADF00D);

    do_txn(0, 1, 16'h0000, 32'h55AA55AA, 0, a, r);
    do_txn(0, 1, 16'h0400, 32'h7777_7777, 0, a, r);
    do_txn(1, 0, 16'h0000, '0, 0, a, r);
    chk("addr_0400", mem_data_out,
        ERR_BUILD ? 32'h55AA55AA : 32'h7777_7777);
    do_txn(1, 0, 16'h0400, '0, 0, a, r);
    chk("rd_0400", mem_data_out, ERR_BUILD ? 32'h0 : 32'h7777_7777);

    @(negedge clk);
    z_addr = 16'h0005; z_din = 32'hCAFEF00D; z_wr = 1;
    n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      @(negedge clk);
      if (z_ready) n = 1;
    end
    z_wr = 0;
    chk("w0_wr_done", n, 1);
    @(negedge clk);
    z_rd = 1;
    pulses = 0; adj = 0; prev = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (z_ready) begin
        pulses++;
        chk("w0_data", z_dout, 32'hCAFEF00D);
        if (prev) adj++;
      end
      prev = z_ready;
    end
    z_rd = 0;
    chk("w0_pulses", pulses, 6);
    chk("w0_no_adjacent", adj, 0);
    repeat (3) @(negedge clk);
    chk("w0_idle_busy", {31'b0, z_busy}, 0);
    chk("w0_err", {31'b0, z_err}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
